// File: rtl/prio_pkg.sv
// Shared sizing and helpers for the request-capture / priority-encoder path.
// Highest set index wins, matching the downstream 8-to-3 encoder.
package prio_pkg;
    localparam int N            = 8;
    localparam int IDX_W        = $clog2(N);
    localparam int SYNC_STG_MIN = 2;

    function automatic logic [IDX_W-1:0] prio_enc(input logic [N-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/prio_sync_edge.sv
// Multi-flop synchroniser for one asynchronous request line, followed by a
// rising-edge detector so a held level produces a single event pulse.
module prio_sync_edge #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic evt
);
    logic [SYNC_STG-1:0] sync_q;
    logic                dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], req};
            dly_q  <= sync_q[SYNC_STG-1];
        end
    end

    assign evt = sync_q[SYNC_STG-1] & ~dly_q;
endmodule

// File: rtl/prio_req_capture.sv
// Captures async request edges into sticky pending bits and offers the highest
// eligible index over valid/ready; an accepted index clears its pending bit.
module prio_req_capture
    import prio_pkg::*;
#(
    parameter int SYNC_STG = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     mask_i,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     pending_o,
    output logic [N-1:0]     overrun_o,
    input  logic [N-1:0]     ovr_clr
);
    // Fewer than two stages is not a safe synchroniser, so clamp upward.
    localparam int STG = (SYNC_STG < SYNC_STG_MIN) ? SYNC_STG_MIN : SYNC_STG;

    logic [N-1:0]     evt;
    logic [N-1:0]     acc_vec;
    logic [N-1:0]     elig;
    logic [IDX_W-1:0] best;
    logic             accept;

    for (genvar k = 0; k < N; k++) begin : g_sync
        prio_sync_edge #(.SYNC_STG(STG)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (req_i[k]),
            .evt   (evt[k])
        );
    end

    assign accept = out_valid && out_ready;
    assign elig   = pending_o & ~mask_i;
    assign best   = prio_enc(elig);

    always_comb begin
        acc_vec = '0;
        if (accept) acc_vec[out_idx] = 1'b1;
    end

    // A new event coinciding with the accept of the same bit re-arms it
    // instead of flagging an overrun; overrun set beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_o <= '0;
            overrun_o <= '0;
        end else begin
            pending_o <= (pending_o | evt) & ~(acc_vec & ~evt);
            overrun_o <= (overrun_o & ~ovr_clr) | (evt & pending_o & ~acc_vec);
        end
    end

    // The accept cycle always drops valid, leaving a bubble so the next
    // selection is made from the already-cleared pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else if (accept) begin
            out_valid <= 1'b0;
        end else if (!out_valid && (|elig)) begin
            out_valid <= 1'b1;
            out_idx   <= best;
        end
    end
endmodule
